// File: rtl/layer_stream_bridge.sv
// Inter-layer buffer: captures a multi-kernel feature-map set, then replays it channel by channel.
// Define LAYER_BRIDGE_PINGPONG_EN for two banks (fill one while the other replays).
module layer_stream_bridge #(
  parameter int NumberOfK          = 4,
  parameter int ProcessingElements = 2,
  parameter int BitSize            = 8,
  parameter int ImageWidth         = 16,
  localparam int ChW               = (NumberOfK > 1) ? $clog2(NumberOfK) : 1
) (
  input  logic                                   clk,
  input  logic                                   res_n,
  input  logic [NumberOfK-1:0]                   in_valid,
  input  logic [ProcessingElements*BitSize-1:0]  in_data,
  output logic                                   in_ready,
  input  logic                                   ds_done,
  output logic                                   out_valid,
  output logic [BitSize-1:0]                     out_data,
  output logic [ChW-1:0]                         out_channel,
  output logic                                   ds_clear,
  output logic                                   out_set_done,
  output logic                                   err
);

  localparam int Pixels = ImageWidth * ImageWidth;
  localparam int CntW   = $clog2(Pixels + 1);
`ifdef LAYER_BRIDGE_PINGPONG_EN
  localparam int NumBanks = 2;
`else
  localparam int NumBanks = 1;
`endif
  localparam int MemDepth = NumBanks * Pixels;
  localparam int MemAW    = (MemDepth > 1) ? $clog2(MemDepth) : 1;

  typedef enum logic [1:0] {S_FILL, S_STREAM, S_WAIT, S_CLEAR} state_t;

  state_t                              r_state;
  state_t                              w_state_next;
  logic [CntW-1:0]                     r_rd_addr;
  logic [ChW-1:0]                      r_channel;
  logic                                r_out_valid;
  logic                                r_err;
  logic [NumberOfK-1:0][CntW-1:0]      w_cnt;
  logic [NumberOfK-1:0][BitSize-1:0]   w_wr_data;
  logic [NumberOfK-1:0][BitSize-1:0]   w_rd_word;
  logic [NumberOfK-1:0]                w_wr_en;
  logic [NumberOfK-1:0]                w_cnt_full;
  logic                                w_all_full;
  logic                                w_drop;
  logic                                w_rd_en;
  logic                                w_last_ch;
  logic                                w_wr_bank;
  logic                                w_rd_bank;
  logic                                w_clear_cnt;
  logic                                w_set_ready;
  logic                                w_next_full;
  logic                                w_in_ready;
  logic [MemAW-1:0]                    w_rd_ptr;

  assign w_all_full = &w_cnt_full;
  assign w_last_ch  = (r_channel == ChW'(NumberOfK - 1));
  assign w_rd_en    = (r_state == S_STREAM) && (r_rd_addr != CntW'(Pixels));
  assign w_rd_ptr   = MemAW'(int'(w_rd_bank) * Pixels + int'(r_rd_addr));

  // Lane i belongs to the i-th set valid bit; lanes past the PE count are dropped.
  always_comb begin : p_lanes
    int lane;
    lane      = 0;
    w_wr_en   = '0;
    w_wr_data = '0;
    w_drop    = 1'b0;
    for (int k = 0; k < NumberOfK; k++) begin
      if (in_valid[k]) begin
        if (!w_in_ready || lane >= ProcessingElements || w_cnt_full[k]) begin
          w_drop = 1'b1;
        end else begin
          w_wr_en[k]   = 1'b1;
          w_wr_data[k] = in_data[lane*BitSize +: BitSize];
        end
        lane++;
      end
    end
  end

  for (genvar gi = 0; gi < NumberOfK; gi++) begin : g_ch
    logic [CntW-1:0]    r_cnt;
    logic [BitSize-1:0] r_mem [MemDepth];
    logic [BitSize-1:0] r_rd_q;
    logic [MemAW-1:0]   w_wr_ptr;

    assign w_wr_ptr       = MemAW'(int'(w_wr_bank) * Pixels + int'(r_cnt));
    assign w_cnt[gi]      = r_cnt;
    assign w_cnt_full[gi] = (r_cnt == CntW'(Pixels));
    assign w_rd_word[gi]  = r_rd_q;

    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
        r_cnt <= '0;
      end else if (w_clear_cnt) begin
        r_cnt <= '0;
      end else if (w_wr_en[gi]) begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (w_wr_en[gi]) begin
        r_mem[w_wr_ptr] <= w_wr_data[gi];
      end
      if (w_rd_en && r_channel == ChW'(gi)) begin
        r_rd_q <= r_mem[w_rd_ptr];
      end
    end
  end

`ifdef LAYER_BRIDGE_PINGPONG_EN
  logic [1:0] r_full;
  logic       r_wr_bank;
  logic       r_rd_bank;
  logic       w_commit;

  // Commit on the edge that completes the set, so the next set can start immediately.
  always_comb begin
    w_commit = 1'b1;
    for (int k = 0; k < NumberOfK; k++) begin
      if (w_cnt[k] + CntW'(w_wr_en[k]) != CntW'(Pixels)) w_commit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      if (w_commit) begin
        r_full[r_wr_bank] <= 1'b1;
        r_wr_bank         <= ~r_wr_bank;
      end
      if (r_state == S_CLEAR && w_last_ch) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
    end
  end

  assign w_wr_bank   = r_wr_bank;
  assign w_rd_bank   = r_rd_bank;
  assign w_clear_cnt = w_commit;
  assign w_set_ready = r_full[r_rd_bank];
  assign w_next_full = r_full[~r_rd_bank];
  assign w_in_ready  = !r_full[r_wr_bank];
`else
  assign w_wr_bank   = 1'b0;
  assign w_rd_bank   = 1'b0;
  assign w_clear_cnt = (r_state == S_FILL) && w_all_full;
  assign w_set_ready = w_all_full;
  assign w_next_full = 1'b0;
  assign w_in_ready  = (r_state == S_FILL);
`endif

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) r_state <= S_FILL;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FILL:   if (w_set_ready) w_state_next = S_STREAM;
      // One drain cycle after the last read so WAIT starts after the last out_valid.
      S_STREAM: if (r_rd_addr == CntW'(Pixels)) w_state_next = S_WAIT;
      S_WAIT:   if (ds_done) w_state_next = S_CLEAR;
      S_CLEAR:  w_state_next = (!w_last_ch || w_next_full) ? S_STREAM : S_FILL;
      default:  w_state_next = S_FILL;
    endcase
  end

  always_comb begin
    in_ready     = w_in_ready;
    ds_clear     = (r_state == S_CLEAR);
    out_set_done = (r_state == S_CLEAR) && w_last_ch;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_rd_addr   <= '0;
      r_channel   <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= w_rd_en;
      r_err       <= r_err | w_drop;
      if (r_state == S_STREAM && r_rd_addr != CntW'(Pixels)) r_rd_addr <= r_rd_addr + CntW'(1);
      else                                                   r_rd_addr <= '0;
      if (r_state == S_CLEAR) r_channel <= w_last_ch ? '0 : r_channel + ChW'(1);
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_valid ? w_rd_word[r_channel] : '0;
  assign out_channel = r_channel;
  assign err         = r_err;

endmodule

// File: tb/tb_layer_stream_bridge.sv
// Directed-sequence bench with random pixel data, checked against per-channel FIFO model.
module tb_layer_stream_bridge;

  localparam int K   = 4;
  localparam int PE  = 2;
  localparam int BW  = 8;
  localparam int IW  = 2;
  localparam int PIX = IW * IW;
  localparam int CW  = 2;
`ifdef LAYER_BRIDGE_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               res_n = 1'b0;
  logic [K-1:0]       in_valid = '0;
  logic [PE*BW-1:0]   in_data = '0;
  logic               ds_done = 1'b0;
  logic               in_ready;
  logic               out_valid;
  logic [BW-1:0]      out_data;
  logic [CW-1:0]      out_channel;
  logic               ds_clear;
  logic               out_set_done;
  logic               err;

  int total = 0;
  int bad   = 0;
  logic [BW-1:0] m_q [K][$];
  int            m_cnt [K];

  layer_stream_bridge #(
    .NumberOfK(K), .ProcessingElements(PE), .BitSize(BW), .ImageWidth(IW)
  ) dut (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ds_done(ds_done), .out_valid(out_valid),
    .out_data(out_data), .out_channel(out_channel), .ds_clear(ds_clear),
    .out_set_done(out_set_done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_full();
    for (int k = 0; k < K; k++) if (m_cnt[k] != PIX) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_reset_vals();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_channel", out_channel, 0);
    chk("rst_ds_clear", ds_clear, 0);
    chk("rst_set_done", out_set_done, 0);
    chk("rst_err", err, 0);
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    #1;
    check_reset_vals();
    for (int k = 0; k < K; k++) begin
      m_q[k].delete();
      m_cnt[k] = 0;
    end
    @(negedge clk);
    res_n = 1'b1;
    tick();
  endtask

  // Model: lane i feeds the i-th set bit; beyond PE lanes or a full channel, the pixel is lost.
  task automatic drive(input logic [K-1:0] v);
    int lane;
    logic [PE*BW-1:0] d;
    lane = 0;
    d = (PE*BW)'($urandom);
    chk("in_ready_fill", in_ready, 1);
    for (int k = 0; k < K; k++) begin
      if (v[k]) begin
        if (lane < PE && m_cnt[k] < PIX) begin
          m_q[k].push_back(d[lane*BW +: BW]);
          m_cnt[k]++;
        end
        lane++;
      end
    end
    in_valid = v;
    in_data  = d;
    tick();
  endtask

  task automatic feed_set(input int mode, input bit standalone, input bit strobe);
    int cyc;
    int n;
    logic [K-1:0] v;
    cyc = 0;
    for (int k = 0; k < K; k++) m_cnt[k] = 0;
    while (!all_full() && cyc < 100) begin
      if (mode == 0) begin
        v = cyc[0] ? 4'b1100 : 4'b0011;
      end else begin
        v = K'($urandom);
        n = 0;
        for (int k = 0; k < K; k++) begin
          if (m_cnt[k] == PIX) v[k] = 1'b0;
          if (v[k]) begin
            if (n >= PE) v[k] = 1'b0;
            else n++;
          end
        end
      end
      if (mode == 2 && cyc == 0) v = 4'b0111;
      if (mode == 3 && cyc < 5) v = 4'b0001;
      drive(v);
      if (mode == 2 && cyc == 0) chk("err_excess_lane", err, 1);
      if (mode == 3 && cyc == 3) chk("err_before_overflow", err, 0);
      if (mode == 3 && cyc == 4) chk("err_overflow", err, 1);
      cyc++;
    end
    in_valid = '0;
    chk("feed_bound", 32'(cyc < 100), 1);
    if (standalone) begin
      chk("ready_last_fill_cycle", in_ready, 1);
      chk("no_early_valid", out_valid, 0);
      if (strobe) in_valid = 4'b0001;
      tick();
      in_valid = '0;
      chk("ready_after_set", in_ready, PP ? 1 : 0);
      chk("no_early_valid2", out_valid, 0);
      tick();
      if (strobe) chk("err_not_ready", err, 1);
    end
  endtask

  task automatic check_channel(input int ch, input bit hold, input bit cont);
    int waits;
    logic [BW-1:0] exp;
    for (int p = 0; p < PIX; p++) begin
      exp = (m_q[ch].size() > 0) ? m_q[ch].pop_front() : 'x;
      chk("out_valid", out_valid, 1);
      chk("out_channel", out_channel, ch);
      chk("out_data", out_data, exp);
      $display("replay ch=%0d px=%0d data=%0h exp=%0h", ch, p, out_data, exp);
      ds_done = hold;
      tick();
    end
    ds_done = 1'b0;
    chk("valid_end", out_valid, 0);
    waits = hold ? 2 : $urandom_range(0, 3);
    repeat (waits) begin
      chk("no_clear_in_wait", ds_clear, 0);
      tick();
    end
    ds_done = 1'b1;
    tick();
    ds_done = 1'b0;
    chk("ds_clear", ds_clear, 1);
    chk("set_done", out_set_done, 32'(ch == K - 1));
    chk("clear_no_valid", out_valid, 0);
    tick();
    chk("clear_once", ds_clear, 0);
    chk("set_done_once", out_set_done, 0);
    if (ch == K - 1) chk("ready_after_set_done", in_ready, 1);
    if (cont) begin
      chk("gap_before_next", out_valid, 0);
      tick();
    end
  endtask

  task automatic check_set(input bit hold0, input int stop_ch, input bit cont_last);
    for (int ch = 0; ch < K; ch++) begin
      if (ch == stop_ch) begin
        chk("stop_valid", out_valid, 1);
        chk("stop_channel", out_channel, ch);
        return;
      end
      check_channel(ch, hold0 && ch == 0, (ch < K - 1) || cont_last);
    end
  endtask

  initial begin
    for (int k = 0; k < K; k++) m_cnt[k] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    res_n = 1'b1;
    tick();

    // Alternating lane mapping, ds_done held through channel 0 replay.
    feed_set(0, 1'b1, 1'b0);
    check_set(1'b1, -1, 1'b0);
    chk("err_clean_set", err, 0);

    // Excess valid bit, then reset during channel 1 replay.
    feed_set(2, 1'b1, 1'b0);
    check_set(1'b0, 1, 1'b0);
    do_reset();

    // Channel overflow on a fresh set.
    feed_set(3, 1'b1, 1'b0);
    check_set(1'b0, -1, 1'b0);

`ifdef LAYER_BRIDGE_PINGPONG_EN
    // Second set fills while the first replays, then follows straight on.
    do_reset();
    feed_set(1, 1'b1, 1'b0);
    fork
      feed_set(1, 1'b0, 1'b0);
      check_set(1'b0, -1, 1'b1);
    join
    check_set(1'b0, -1, 1'b0);
`else
    // Write attempted while in_ready is low.
    do_reset();
    feed_set(1, 1'b1, 1'b1);
    check_set(1'b0, -1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
